// File: rtl/mul_seq_mac.sv
// mul_seq_mac: sequential SIZE x SIZE multiply / multiply-accumulate engine.
// Radix-2 shift-add on operand magnitudes over SIZE cycles, then sign and
// fractional correction, then MR <- P, MR + P, MR - P or 0.
//
// Optional feature macro: MUL_SAT_EN (MR saturates on overflow instead of
// wrapping; mul_ovf reports overflow in both builds).
//
// Ports:
//   clk        in   clock, all state on rising edge
//   reset      in   synchronous active-high reset
//   start      in   request, sampled only in IDLE
//   op_a/op_b  in   SIZE-bit operands, latched on accepted start
//   mul_signed in   1 = two's complement operands
//   mul_frac   in   1 = fractional (product << 1)
//   mul_op     in   00 MR=P, 01 MR+=P, 10 MR-=P, 11 MR=0
//   busy       out  high from cycle after start through the done cycle
//   done       out  one-cycle pulse, mul_out valid
//   mul_out    out  MR register (SIZE*5/2 bits)
//   mul_ovf    out  accumulate overflow, updated with MR
//
// state  | meaning
// IDLE   | waiting for start
// CALC   | SIZE shift-add iterations on magnitudes
// ACC    | sign/frac correction and MR update
// DONE   | done pulse, back to IDLE
module mul_seq_mac #(
  parameter int SIZE = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [SIZE-1:0]       op_a,
  input  logic [SIZE-1:0]       op_b,
  input  logic                  mul_signed,
  input  logic                  mul_frac,
  input  logic [1:0]            mul_op,
  output logic                  busy,
  output logic                  done,
  output logic [SIZE*5/2-1:0]   mul_out,
  output logic                  mul_ovf
);

  localparam int MW = SIZE * 5 / 2;
  localparam int PW = 2 * SIZE;
  localparam int CW = $clog2(SIZE);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ACC, S_DONE} state_t;

  state_t          r_state;
  logic [PW-1:0]   r_mcand;
  logic [SIZE-1:0] r_mplier;
  logic [PW-1:0]   r_acc2;
  logic [CW-1:0]   r_cnt;
  logic            r_neg;
  logic            r_signed;
  logic            r_frac;
  logic [1:0]      r_op;
  logic [MW-1:0]   r_mr;
  logic            r_busy;
  logic            r_done;
  logic            r_ovf;

  // Operand magnitudes; the most negative value maps to itself and is
  // then treated as an unsigned SIZE-bit magnitude.
  logic            w_a_neg, w_b_neg;
  logic [SIZE-1:0] w_a_mag, w_b_mag;

  assign w_a_neg = mul_signed & op_a[SIZE-1];
  assign w_b_neg = mul_signed & op_b[SIZE-1];
  assign w_a_mag = w_a_neg ? (SIZE'(0) - op_a) : op_a;
  assign w_b_mag = w_b_neg ? (SIZE'(0) - op_b) : op_b;

  logic [PW-1:0] w_p;
  logic [MW-1:0] w_pext;
  logic [MW-1:0] w_pf;
  logic [MW:0]   w_sum;
  logic [MW:0]   w_dif;
  logic [MW-1:0] w_mr_nxt;
  logic          w_ovf_nxt;

  assign w_p    = r_neg ? (PW'(0) - r_acc2) : r_acc2;
  assign w_pext = r_signed ? {{(MW-PW){w_p[PW-1]}}, w_p} : {{(MW-PW){1'b0}}, w_p};
  assign w_pf   = r_frac ? {w_pext[MW-2:0], 1'b0} : w_pext;
  // Extra MSB carries the unsigned carry/borrow out.
  assign w_sum  = {1'b0, r_mr} + {1'b0, w_pf};
  assign w_dif  = {1'b0, r_mr} - {1'b0, w_pf};

  always_comb begin
    w_mr_nxt  = w_pf;
    w_ovf_nxt = 1'b0;
    case (r_op)
      2'b00: w_mr_nxt = w_pf;
      2'b01: begin
        w_mr_nxt  = w_sum[MW-1:0];
        w_ovf_nxt = r_signed ? ((r_mr[MW-1] == w_pf[MW-1]) && (w_sum[MW-1] != r_mr[MW-1]))
                             : w_sum[MW];
      end
      2'b10: begin
        w_mr_nxt  = w_dif[MW-1:0];
        // Subtraction overflows when MR and -P share a sign, i.e. MR and P differ.
        w_ovf_nxt = r_signed ? ((r_mr[MW-1] != w_pf[MW-1]) && (w_dif[MW-1] != r_mr[MW-1]))
                             : w_dif[MW];
      end
      default: w_mr_nxt = '0;
    endcase
`ifdef MUL_SAT_EN
    if (w_ovf_nxt) begin
      if (r_signed) begin
        // Signed overflow always moves away from MR's own sign.
        w_mr_nxt = r_mr[MW-1] ? {1'b1, {(MW-1){1'b0}}} : {1'b0, {(MW-1){1'b1}}};
      end else begin
        w_mr_nxt = (r_op == 2'b01) ? {MW{1'b1}} : {MW{1'b0}};
      end
    end
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc2   <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_signed <= 1'b0;
      r_frac   <= 1'b0;
      r_op     <= 2'b00;
      r_mr     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_signed <= mul_signed;
            r_frac   <= mul_frac;
            r_op     <= mul_op;
            r_neg    <= w_a_neg ^ w_b_neg;
            r_mcand  <= {{(PW-SIZE){1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_acc2   <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            if (mul_op == 2'b11) begin
              r_mr    <= '0;
              r_ovf   <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (r_mplier[0]) r_acc2 <= r_acc2 + r_mcand;
          r_mplier <= r_mplier >> 1;
          r_mcand  <= r_mcand << 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CW'(SIZE-1)) r_state <= S_ACC;
        end
        S_ACC: begin
          r_mr    <= w_mr_nxt;
          r_ovf   <= w_ovf_nxt;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign mul_out = r_mr;
  assign mul_ovf = r_ovf;

endmodule

// File: tb/tb_mul_seq_mac.sv
// Scoreboard bench for mul_seq_mac: the driver pushes the hand-computed
// result, overflow flag and latency for each accepted start; a monitor pops
// and compares whenever done is seen.
module tb_mul_seq_mac;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        mul_signed = 1'b0;
  logic        mul_frac = 1'b0;
  logic [1:0]  mul_op = 2'b00;
  logic        busy;
  logic        done;
  logic [39:0] mul_out;
  logic        mul_ovf;

  mul_seq_mac #(.SIZE(16)) dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .mul_signed(mul_signed), .mul_frac(mul_frac), .mul_op(mul_op),
    .busy(busy), .done(done), .mul_out(mul_out), .mul_ovf(mul_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0] out;
    logic        ovf;
    int          lat;
    int          e0;
  } exp_t;

  exp_t sb[$];
  int   n_edge = 0;
  int   busy_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) n_edge <= n_edge + 1;

  function automatic void chk(string name, logic [39:0] got, logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_cnt++;
    else busy_cnt = 0;
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no done (mul_out %h)", mul_out);
      end else begin
        e = sb.pop_front();
        chk("mul_out", mul_out, e.out);
        chk("mul_ovf", 40'(mul_ovf), 40'(e.ovf));
        chk("latency", 40'(n_edge - e.e0 + 1), 40'(e.lat));
        chk("busy_cycles", 40'(busy_cnt), 40'(e.lat));
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sg,
                       input logic fr, input logic [1:0] op,
                       input logic [39:0] eo, input logic eov);
    exp_t e;
    @(negedge clk);
    op_a = a; op_b = b; mul_signed = sg; mul_frac = fr; mul_op = op;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.out = eo;
    e.ovf = eov;
    e.lat = (op == 2'b11) ? 1 : 18;
    e.e0  = n_edge;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", t);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input logic [15:0] a, input logic [15:0] b, input logic sg,
                     input logic fr, input logic [1:0] op,
                     input logic [39:0] eo, input logic eov);
    issue(a, b, sg, fr, op, eo, eov);
    wait_idle();
  endtask

  initial begin
    logic [39:0] acc;
    repeat (3) @(negedge clk);
    chk("rst_mul_out", mul_out, 40'h0);
    chk("rst_busy", 40'(busy), 40'h0);
    chk("rst_done", 40'(done), 40'h0);
    chk("rst_ovf", 40'(mul_ovf), 40'h0);
    reset = 1'b0;

    // Unsigned integer, signed accumulate / subtract
    run(16'h0003, 16'h0005, 1'b0, 1'b0, 2'b00, 40'h000000000F, 1'b0);
    run(16'h0004, 16'h0004, 1'b1, 1'b0, 2'b00, 40'h0000000010, 1'b0);
    run(16'hFFFE, 16'h0003, 1'b1, 1'b0, 2'b01, 40'h000000000A, 1'b0);
    run(16'hFFFE, 16'h0003, 1'b1, 1'b0, 2'b10, 40'h0000000010, 1'b0);

    // Fractional signed, including the most-negative corner
    run(16'h4000, 16'h4000, 1'b1, 1'b1, 2'b00, 40'h0020000000, 1'b0);
    run(16'h8000, 16'h8000, 1'b1, 1'b1, 2'b00, 40'h0080000000, 1'b0);

    // Clear
    run(16'h1111, 16'h2222, 1'b0, 1'b0, 2'b11, 40'h0, 1'b0);

    // Second start during CALC is ignored
    issue(16'h0007, 16'h0009, 1'b0, 1'b0, 2'b00, 40'h000000003F, 1'b0);
    repeat (5) @(negedge clk);
    op_a = 16'h1234; op_b = 16'h0055; mul_op = 2'b00;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    repeat (25) @(negedge clk);

    // Unsigned borrow: 0x3F - 0x100
`ifdef MUL_SAT_EN
    run(16'h0010, 16'h0010, 1'b0, 1'b0, 2'b10, 40'h0000000000, 1'b1);
`else
    run(16'h0010, 16'h0010, 1'b0, 1'b0, 2'b10, 40'hFFFFFFFF3F, 1'b1);
`endif
    run(16'h0000, 16'h0000, 1'b0, 1'b0, 2'b11, 40'h0, 1'b0);

    // Signed overflow: MR = -1, then add 2^31 256 times to reach 0x7FFFFFFFFF
    run(16'hFFFF, 16'h0001, 1'b1, 1'b0, 2'b00, 40'hFFFFFFFFFF, 1'b0);
    acc = 40'hFFFFFFFFFF;
    for (int i = 1; i <= 256; i++) begin
      acc = acc + (40'h1 << 31);
      run(16'h8000, 16'h8000, 1'b1, 1'b1, 2'b01, acc, 1'b0);
    end
    chk("acc_reach_max", mul_out, 40'h7FFFFFFFFF);
`ifdef MUL_SAT_EN
    run(16'h0001, 16'h0001, 1'b1, 1'b0, 2'b01, 40'h7FFFFFFFFF, 1'b1);
`else
    run(16'h0001, 16'h0001, 1'b1, 1'b0, 2'b01, 40'h8000000000, 1'b1);
`endif
    // Overflow flag holds between operations, then clears on the next update
    chk("ovf_hold", 40'(mul_ovf), 40'h1);
    run(16'h0003, 16'h0005, 1'b0, 1'b0, 2'b00, 40'h000000000F, 1'b0);

    // Reset mid-operation discards it
    issue(16'h0003, 16'h0005, 1'b0, 1'b0, 2'b00, 40'h000000000F, 1'b0);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    chk("midrst_busy", 40'(busy), 40'h0);
    chk("midrst_done", 40'(done), 40'h0);
    chk("midrst_out", mul_out, 40'h0);
    chk("midrst_ovf", 40'(mul_ovf), 40'h0);
    repeat (25) @(negedge clk);
    run(16'h0002, 16'h0003, 1'b0, 1'b0, 2'b00, 40'h0000000006, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
